// File: rtl/mux_32.sv
// 32:1 word multiplexer over a flat packed bus: a zero-latency combinational
// output plus a registered copy carrying the select and a valid flag.
module mux_32 #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [SEL_W-1:0]                  mux_sel,
    input  logic [(2**SEL_W)*DATA_W-1:0]      mux_data_in,
    output logic [DATA_W-1:0]                 mux_data_out,
    output logic [DATA_W-1:0]                 mux_data_out_q,
    output logic [SEL_W-1:0]                  mux_sel_q,
    output logic                              mux_valid_q
);

    localparam int unsigned N = 2**SEL_W;

    logic [DATA_W-1:0] tree [N];
    logic [DATA_W-1:0] mux_data_out_d;
    logic [SEL_W-1:0]  mux_sel_d;
    logic              mux_valid_d;

    // Log-tree of 2:1 muxes, LSB of the select resolves adjacent lane pairs
    // first. Reduction is in place: entry j at each level only reads entries
    // 2j and 2j+1, which have not yet been overwritten at that level.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            tree[i] = mux_data_in[i*DATA_W +: DATA_W];
        end
        for (int unsigned l = 0; l < SEL_W; l++) begin
            for (int unsigned j = 0; j < (N >> (l + 1)); j++) begin
                tree[j] = mux_sel[l] ? tree[2*j+1] : tree[2*j];
            end
        end
    end

    assign mux_data_out = tree[0];

    always_comb begin
        mux_data_out_d = mux_data_out;
        mux_sel_d      = mux_sel;
        mux_valid_d    = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mux_data_out_q <= '0;
            mux_sel_q      <= '0;
            mux_valid_q    <= 1'b0;
        end else begin
            mux_data_out_q <= mux_data_out_d;
            mux_sel_q      <= mux_sel_d;
            mux_valid_q    <= mux_valid_d;
        end
    end

endmodule

// File: tb/tb_mux_32.sv
// Directed and random checks of the combinational and registered paths of
// mux_32, using immediate assertions at every comparison point.
module tb_mux_32;

    logic          clk;
    logic          rst;
    logic [4:0]    sel;
    logic [1023:0] data_in;
    logic [31:0]   data_out;
    logic [31:0]   data_out_q;
    logic [4:0]    sel_q;
    logic          valid_q;

    int unsigned checks;
    int unsigned passes;

    mux_32 #(.DATA_W(32), .SEL_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .mux_sel       (sel),
        .mux_data_in   (data_in),
        .mux_data_out  (data_out),
        .mux_data_out_q(data_out_q),
        .mux_sel_q     (sel_q),
        .mux_valid_q   (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_incrementing();
        for (int i = 0; i < 32; i++) data_in[i*32 +: 32] = 32'(i + 1);
    endtask

    logic [31:0] exp_now;
    logic [31:0] exp_prev;
    logic [4:0]  sel_prev;

    initial begin
        checks  = 0;
        passes  = 0;
        rst     = 1'b1;
        sel     = 5'd0;
        data_in = '0;

        // Reset held for two clocks
        tick();
        tick();
        check("rst_data_q", data_out_q, 32'h0);
        check("rst_sel_q", {27'h0, sel_q}, 32'h0);
        check("rst_valid_q", {31'h0, valid_q}, 32'h0);

        // Release, sel=3 with incrementing lanes
        rst = 1'b0;
        load_incrementing();
        sel = 5'd3;
        #1;
        check("sel3_comb", data_out, 32'd4);
        tick();
        check("sel3_data_q", data_out_q, 32'd4);
        check("sel3_sel_q", {27'h0, sel_q}, 32'd3);
        check("sel3_valid_q", {31'h0, valid_q}, 32'd1);

        // Incrementing sweep with a one-clock reset at sel=20
        for (int s = 0; s < 32; s++) begin
            sel = 5'(s);
            rst = (s == 20);
            #1;
            check("sweep_comb", data_out, 32'(s + 1));
            tick();
            if (s == 20) begin
                check("midrst_data_q", data_out_q, 32'h0);
                check("midrst_sel_q", {27'h0, sel_q}, 32'h0);
                check("midrst_valid_q", {31'h0, valid_q}, 32'h0);
                check("midrst_comb", data_out, 32'd21);
            end else begin
                check("sweep_data_q", data_out_q, 32'(s + 1));
                check("sweep_sel_q", {27'h0, sel_q}, 32'(s));
                check("sweep_valid_q", {31'h0, valid_q}, 32'd1);
            end
        end
        rst = 1'b0;

        // Boundary lanes
        data_in = '0;
        data_in[31:0]      = 32'hDEADBEEF;
        data_in[1023:992]  = 32'hFFFFFFFF;
        sel = 5'd0;  #1; check("bound_sel0", data_out, 32'hDEADBEEF);
        sel = 5'd31; #1; check("bound_sel31", data_out, 32'hFFFFFFFF);
        sel = 5'd15; #1; check("bound_sel15", data_out, 32'h00000000);
        sel = 5'd1;  #1; check("bound_sel1", data_out, 32'h00000000);
        sel = 5'd30; #1; check("bound_sel30", data_out, 32'h00000000);

        // Walking one per lane
        for (int i = 0; i < 32; i++) data_in[i*32 +: 32] = 32'h1 << i;
        for (int s = 0; s < 32; s++) begin
            sel = 5'(s);
            #1;
            check("walk_one", data_out, 32'h1 << s);
        end

        // Data change with select held: same-cycle update
        tick();
        sel = 5'd7;
        #1;
        check("hold7_before", data_out, 32'h00000080);
        data_in[7*32 +: 32] = 32'hA5A55A5A;
        #1;
        check("hold7_after", data_out, 32'hA5A55A5A);
        data_in[8*32 +: 32] = 32'h12345678;
        #1;
        check("hold7_neighbour", data_out, 32'hA5A55A5A);

        // Simultaneous select and data change
        data_in[12*32 +: 32] = 32'hCAFEF00D;
        sel = 5'd12;
        #1;
        check("simul_change", data_out, 32'hCAFEF00D);

        // Random regression against an independent lane slice
        exp_prev = '0;
        sel_prev = '0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (c > 0) begin
                check("rand_data_q", data_out_q, exp_prev);
                check("rand_sel_q", {27'h0, sel_q}, {27'h0, sel_prev});
            end
            for (int i = 0; i < 32; i++) data_in[i*32 +: 32] = $urandom;
            sel = 5'($urandom_range(31, 0));
            exp_now = data_in[int'(sel)*32 +: 32];
            #1;
            check("rand_comb", data_out, exp_now);
            exp_prev = exp_now;
            sel_prev = sel;
        end
        tick();
        check("rand_last_data_q", data_out_q, exp_prev);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mux_32.md
Name:
mux_32

Overview:
- 32:1 word multiplexer. Selects one 32-bit lane out of a flat 1024-bit packed bus.
- Lane i occupies bits [i*32+31 : i*32].
- Provides two outputs:
  - a zero-latency combinational output, used by the matrix-multiply datapath for operand selection;
  - a registered copy with a valid flag, for timing-closed consumers.

Parameters:
- DATA_W, 32, width of one lane in bits.
- SEL_W, 5, select width. Lane count N = 2**SEL_W = 32. Input bus width = N*DATA_W = 1024.

Ports:
- clk  in  1  rising-edge clock; used only by the registered path.
- rst  in  1  synchronous, active-high reset; affects only the registered path.
- mux_sel  in  5  lane index, 0..31.
- mux_data_in  in  1024  packed lanes; lane i = mux_data_in[i*32 +: 32].
- mux_data_out  out  32  combinational selected lane.
- mux_data_out_q  out  32  registered selected lane.
- mux_sel_q  out  5  registered copy of mux_sel, aligned with mux_data_out_q.
- mux_valid_q  out  1  registered-path valid flag.

Behaviour:
- Clocking: one clock domain (clk). Reset is synchronous and active-high (rst).
- Combinational path:
  - mux_data_out = mux_data_in[mux_sel*32 +: 32] at all times.
  - Purely combinational: no dependence on clk or rst, no latches.
  - Must settle within the same delta/cycle that mux_sel or mux_data_in changes.
  - A value applied just after a clock edge must be visible at the next edge.
- Full decode: all 32 select codes are valid; there is no out-of-range case. Lane 0 = bits [31:0]; lane 31 = bits [1023:992].
- Unknown select: if mux_sel contains X/Z, mux_data_out may be X (simulation only). No default lane is substituted.
- Registered path, on each rising clk:
  - rst=1: mux_data_out_q <= 0, mux_sel_q <= 0, mux_valid_q <= 0.
  - otherwise: mux_data_out_q <= current mux_data_out, mux_sel_q <= mux_sel, mux_valid_q <= 1.
- Latency:
  - combinational output: 0 cycles;
  - registered outputs: exactly 1 cycle after the sampling edge.
- mux_valid_q is low after reset and rises on the first non-reset edge.
- Reset mid-operation:
  - asserting rst clears the registered outputs on that edge;
  - the combinational output keeps tracking its inputs unaffected;
  - on release, the first non-reset edge captures the then-current lane.
- Simultaneous change of mux_sel and mux_data_in: the output reflects the new select applied to the new data. No ordering dependence.
- No handshake, no back-pressure, no internal state beyond the three output registers.
- Structure is implementation choice (case statement, indexed part-select, or log-tree of 2:1 muxes). The result must be bit-identical for every lane.

Test Plan:
- Incrementing sweep:
  - load lane i = i+1 for i=0..31;
  - sweep mux_sel 0→31, one value per clock;
  - at each following rising edge, mux_data_out == mux_sel+1 (sel=0 → 1, sel=31 → 32);
  - no mismatches.
- Boundary lanes:
  - lane 0 = 0xDEADBEEF, lane 31 = 0xFFFFFFFF, all others 0;
  - sel=0 → 0xDEADBEEF; sel=31 → 0xFFFFFFFF; sel=15 → 0x00000000.
  - Confirms lane bit-slice ordering and no neighbour bleed.
- Walking-one per lane:
  - lane i = 1<<i;
  - each sel value yields exactly one set bit at position sel.
  - Then change mux_data_in with sel held at 7 → output updates in the same cycle.
- Registered path:
  - rst=1 for 2 clocks → mux_data_out_q=0, mux_sel_q=0, mux_valid_q=0;
  - release, then apply sel=3 with the incrementing pattern;
  - the next edge gives mux_data_out_q=4, mux_sel_q=3, mux_valid_q=1.
- Reset mid-stream:
  - during the sweep, assert rst at sel=20 for one clock;
  - registered outputs clear to 0 on that edge while mux_data_out still reads 21;
  - after release, mux_data_out_q resumes with a 1-cycle lag (sel=22 → 23 on the following edge).
- Random regression:
  - 1000 cycles of random mux_data_in and mux_sel;
  - check mux_data_out against the reference slice every cycle;
  - check mux_data_out_q against the previous cycle's expected value.
